// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops, optional iterative MUL/DIV, valid/ready on both sides.
// Define ALU_MULDIV_EN to build the shift-add multiplier and restoring divider; otherwise MUL/DIV codes are illegal.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cmp_true,
    output logic             overflow,
    output logic             illegal_op
);
    localparam int SHW = $clog2(WIDTH);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, cmp_q, cmp_d, ovf_q, ovf_d, ill_q, ill_d;
    logic             idle, accept;
    logic [WIDTH-1:0] sum, diff, sc_res;
    logic [SHW-1:0]   shamt;
    logic             sc_cmp, sc_ovf, sc_ill;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    // acc: product / partial remainder; sh: multiplier / dividend-then-quotient; opb: multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
    logic             neg_q, neg_d, dz_q, dz_d;
    logic             go_mul, go_div, a_neg, b_neg, ge;
    logic [WIDTH:0]   trial, tdiff;
    logic [WIDTH-1:0] mul_acc, quo, fin_res;

    assign idle  = (state_q == S_IDLE);
    assign a_neg = alu_control[0] && operand_a[WIDTH-1];
    assign b_neg = alu_control[0] && operand_b[WIDTH-1];
`else
    assign idle = 1'b1;
`endif

    assign in_ready = rst_n && idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign sum      = operand_a + operand_b;
    assign diff     = operand_a - operand_b;
    assign shamt    = operand_b[SHW-1:0];

    always_comb begin
        sc_res = '0;
        sc_cmp = 1'b0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
`ifdef ALU_MULDIV_EN
        go_mul = 1'b0;
        go_div = 1'b0;
`endif
        if (!alu_control[4]) begin
            if (alu_control[1]) begin
                sc_ill = 1'b1;
            end else begin
                case (alu_control[3:2])
                    2'b00: begin
                        sc_res = sum;
                        sc_ovf = alu_control[0] && (operand_a[WIDTH-1] == operand_b[WIDTH-1])
                                 && (sum[WIDTH-1] != operand_a[WIDTH-1]);
                    end
                    2'b01: begin
                        sc_res = diff;
                        sc_ovf = alu_control[0] && (operand_a[WIDTH-1] != operand_b[WIDTH-1])
                                 && (diff[WIDTH-1] != operand_a[WIDTH-1]);
                    end
`ifdef ALU_MULDIV_EN
                    2'b10:   go_mul = 1'b1;
                    default: go_div = 1'b1;
`else
                    default: sc_ill = 1'b1;
`endif
                endcase
            end
        end else begin
            case (alu_control[3:0])
                4'b0000: sc_res = operand_a & operand_b;
                4'b0001: sc_res = operand_a | operand_b;
                4'b0010: sc_res = operand_a ^ operand_b;
                4'b0011: sc_res = ~operand_a;
                4'b0100: sc_res = operand_a << shamt;
                4'b0101: sc_res = operand_a >> shamt;
                4'b0110: sc_res = $unsigned($signed(operand_a) >>> shamt);
                4'b0111: sc_res = ~(operand_a | operand_b);
                4'b1000: sc_cmp = (operand_a == operand_b);
                4'b1001: sc_cmp = (operand_a != operand_b);
                4'b1010: sc_cmp = ($signed(operand_a) < $signed(operand_b));
                4'b1011: sc_cmp = ($signed(operand_a) >= $signed(operand_b));
                4'b1100: sc_cmp = (operand_a < operand_b);
                4'b1101: sc_cmp = (operand_a >= operand_b);
                default: sc_ill = 1'b1;
            endcase
            if (alu_control[3] && !sc_ill) sc_res = {{(WIDTH-1){1'b0}}, sc_cmp};
        end
    end

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        cmp_d       = cmp_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
`ifdef ALU_MULDIV_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        trial   = {acc_q, sh_q[WIDTH-1]};
        tdiff   = trial - {1'b0, opb_q};
        ge      = (trial >= {1'b0, opb_q});
        mul_acc = sh_q[0] ? acc_q + opb_q : acc_q;
        quo     = {sh_q[WIDTH-2:0], ge};
        fin_res = '0;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
`ifdef ALU_MULDIV_EN
            state_d = S_IDLE;
            cnt_d   = '0;
`endif
        end else if (accept) begin
`ifdef ALU_MULDIV_EN
            if (go_mul || go_div) begin
                state_d = go_mul ? S_MUL : S_DIV;
                cnt_d   = '0;
                acc_d   = '0;
                if (go_mul) begin
                    sh_d  = operand_b;
                    opb_d = operand_a;
                    neg_d = 1'b0;
                    dz_d  = 1'b0;
                end else begin
                    sh_d  = a_neg ? -operand_a : operand_a;
                    opb_d = b_neg ? -operand_b : operand_b;
                    neg_d = a_neg ^ b_neg;
                    dz_d  = (operand_b == '0);
                end
            end else
`endif
            begin
                out_valid_d = 1'b1;
                result_d    = sc_res;
                zero_d      = (sc_res == '0);
                cmp_d       = sc_cmp;
                ovf_d       = sc_ovf;
                ill_d       = sc_ill;
            end
        end
`ifdef ALU_MULDIV_EN
        else if (state_q != S_IDLE) begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == S_MUL) begin
                acc_d   = mul_acc;
                opb_d   = opb_q << 1;
                sh_d    = sh_q >> 1;
                fin_res = mul_acc;
            end else begin
                acc_d   = ge ? tdiff[WIDTH-1:0] : trial[WIDTH-1:0];
                sh_d    = quo;
                fin_res = dz_q ? '1 : (neg_q ? -quo : quo);
            end
            if (cnt_q == LAST) begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                result_d    = fin_res;
                zero_d      = (fin_res == '0);
                cmp_d       = 1'b0;
                ovf_d       = 1'b0;
                ill_d       = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cmp_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
`ifdef ALU_MULDIV_EN
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            cmp_q       <= cmp_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
`ifdef ALU_MULDIV_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign cmp_true   = cmp_q;
    assign overflow   = ovf_q;
    assign illegal_op = ill_q;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 5-bit alu_control code produced by the ALU control unit, plus two operands.
- Produces a registered result, flags and a branch-condition bit.
- Single-cycle for add/sub/logic/shift/compare; iterative multi-cycle for MUL/DIV.
- Uses a valid/ready handshake on both sides so the pipeline can stall during long ops.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, >= 8.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of in-flight/held op
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- alu_control  in  5  op code (encoding below)
- operand_a  in  WIDTH  first operand
- operand_b  in  WIDTH  second operand / shift amount
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  op result
- zero  out  1  result == 0
- cmp_true  out  1  compare-op outcome (0 for non-compare ops)
- overflow  out  1  signed add/sub overflow
- illegal_op  out  1  code not in table

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid, result, zero, cmp_true, overflow, illegal_op all 0; iteration counter 0. in_ready is 0 while in reset.
- Codes, arithmetic (bit4=0): [3:2] selects 00 ADD, 01 SUB, 10 MUL, 11 DIV; bit0 = signed; bit1 must be 0.
- Codes, logic: 10000 AND, 10001 OR, 10010 XOR, 10011 NOT(~a), 10100 SLL, 10101 SRL, 10110 SRA, 10111 NOR, 11000 EQ, 11001 NE, 11010 LT signed, 11011 GE signed, 11100 LT unsigned, 11101 GE unsigned.
- Illegal codes: any other code (bit4=0 with bit1=1, or 11110/11111) gives a 1-cycle op with result=0 and illegal_op=1.
- Handshake: in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready. Operands and code are captured on accept.
- Output hold: out_valid stays high and all outputs stay stable until out_ready=1. out_valid then drops the next cycle unless a new result completes on that edge.
- State machine:
  - States: IDLE, MUL, DIV.
  - IDLE, on accept of a single-cycle op: the result is registered on the same edge, so out_valid=1 one cycle after accept.
  - IDLE, on accept of MUL/DIV: go to MUL/DIV with counter=0.
  - MUL/DIV: one iteration per cycle for WIDTH cycles. On the edge where counter==WIDTH-1, write the result, set out_valid=1 and return to IDLE. Total latency is WIDTH+1 cycles from accept to out_valid (33 for WIDTH=32).
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow is set only for signed ADD/SUB on sign overflow; 0 for all other ops.
  - MUL returns the low WIDTH bits of the product (shift-add).
  - DIV is restoring division on magnitudes, with sign correction when bit0=1 (truncating toward zero).
  - Divide by zero: result = all ones. No trap.
  - Signed DIV of most-negative by -1: result = most-negative value, overflow=0.
- Shifts: amount = operand_b[SHW-1:0]; upper bits are ignored. SRA sign-fills.
- Compares: result = {WIDTH-1 zeros, cmp}; cmp_true = cmp.
- zero: computed from the final result for every op, including compares.
- flush: forces state=IDLE, out_valid=0, counter=0 on the next edge. flush has priority over accept and over completion in the same cycle. Flags are left unchanged.
- Reset mid-MUL/DIV: abort immediately; no result is produced.

Optional Feature:
- ALU_MULDIV_EN defined:
  - MUL/DIV are iterative as above.
- ALU_MULDIV_EN undefined:
  - MUL/DIV codes are treated as illegal (1-cycle, result=0, illegal_op=1).
  - MUL/DIV states and the iteration datapath are not synthesised.

Test Plan:
- ADD signed: 0x7FFFFFFF + 1 (code 00001) -> after 1 cycle result=0x80000000, overflow=1, zero=0. Same with code 00000 -> overflow=0.
- BLT/BGEU compares: a=0xFFFFFFFF, b=1. Code 11010 -> cmp_true=1, result=1. Code 11101 -> cmp_true=1. Code 11000 -> cmp_true=0, zero=1.
- DIV signed (01101): -100 / 7 -> out_valid exactly 33 cycles after accept, result=-14 (0xFFFFFFF2). in_ready=0 throughout.
- DIV edges: 5/0 -> 0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF signed -> 0x80000000.
- Backpressure: out_ready=0 for 5 cycles after SLL a=1, b=0x21 -> result=2 held stable, in_ready=0. Raise out_ready -> next op accepted the same cycle.
- flush asserted at cycle 10 of MUL 3*5 -> out_valid never rises, in_ready=1 next cycle. Async rst_n pulse mid-DIV -> all outputs 0 immediately.
